// File: rtl/branch_predict_resolve.sv
// Execute-stage branch resolution with a direct-mapped BTB (2-bit counters)
// for fetch prediction, registered mispredict redirect and a wrapping mispredict count.
module branch_predict_resolve #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  f_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_ctrl,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  operandA,
  input  logic [XLEN-1:0]  B_imm,
  input  logic [XLEN-1:0]  J_imm,
  input  logic [XLEN-1:0]  I_imm,
  input  logic             btaken,
  input  logic             jr,
  input  logic             j,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_mispredict_cnt;

  // Fetch-side lookup: purely combinational off registered BTB state.
  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic             w_f_taken;
  logic [XLEN-1:0]  w_f_seq;

  assign w_f_idx   = f_pc[IDX_W+1:2];
  assign w_f_tag   = f_pc[XLEN-1:IDX_W+2];
  assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_f_taken = w_f_hit && r_ctr[w_f_idx][1];
  assign w_f_seq   = f_pc + PC_STEP;

  assign pred_hit    = w_f_hit;
  assign pred_taken  = w_f_taken;
  assign pred_target = w_f_taken ? r_target[w_f_idx] : w_f_seq;

  // Execute-side resolution.
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic [XLEN-1:0]  w_ex_seq;
  logic [XLEN-1:0]  w_jr_sum;
  logic [XLEN-1:0]  w_target;
  logic             w_actual_taken;
  logic             w_resolve;
  logic             w_mispredict;
  logic [XLEN-1:0]  w_correct_pc;

  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_seq = ex_pc + PC_STEP;
  assign w_jr_sum = operandA + I_imm;

  always_comb begin
    w_target = w_ex_seq;
    if (j) begin
      w_target = ex_pc + J_imm;
    end else if (jr) begin
      w_target = {w_jr_sum[XLEN-1:1], 1'b0};
    end else if (btaken) begin
      w_target = ex_pc + B_imm;
    end
  end

  assign w_actual_taken = j | jr | btaken;
  assign w_resolve      = ex_valid & ex_is_ctrl;
  assign w_mispredict   = w_resolve &
                          ((w_actual_taken != ex_pred_taken) |
                           (w_actual_taken & (w_target != ex_pred_target)));
  assign w_correct_pc   = w_actual_taken ? w_target : w_ex_seq;

  // Training is written at the edge, so a same-cycle lookup sees old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'd0;
      end
    end else if (w_resolve) begin
      if (w_ex_hit) begin
        if (w_actual_taken) begin
          r_target[w_ex_idx] <= w_target;
          if (r_ctr[w_ex_idx] != 2'd3) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          end
        end else if (r_ctr[w_ex_idx] != 2'd0) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
      end else if (w_actual_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= w_target;
        r_ctr[w_ex_idx]    <= (j | jr) ? 2'd3 : 2'd2;
      end
    end
  end

  // Redirect is a valid-only pulse: fetch has no ready and must accept it the cycle it is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc    <= w_correct_pc;
        r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
      end
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve (ENTRIES=16, CNT_W=4 so the counter wrap is reachable).
module tb_branch_predict_resolve;

  localparam int XLEN = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [XLEN-1:0]  f_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             ex_valid;
  logic             ex_is_ctrl;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  operandA;
  logic [XLEN-1:0]  B_imm;
  logic [XLEN-1:0]  J_imm;
  logic [XLEN-1:0]  I_imm;
  logic             btaken;
  logic             jr;
  logic             j;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt;

  int checks;
  int errors;

  branch_predict_resolve #(.XLEN(XLEN), .ENTRIES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_ctrl(ex_is_ctrl), .ex_pc(ex_pc),
    .operandA(operandA), .B_imm(B_imm), .J_imm(J_imm), .I_imm(I_imm),
    .btaken(btaken), .jr(jr), .j(j),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_is_ctrl = 1'b0; ex_pc = '0; operandA = '0;
    B_imm = '0; J_imm = '0; I_imm = '0; btaken = 1'b0; jr = 1'b0; j = 1'b0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic drive_branch(input logic [31:0] pc, input logic [31:0] bimm,
                              input logic bt, input logic pt, input logic [31:0] ptgt);
    clear_ex();
    ex_valid = 1'b1; ex_is_ctrl = 1'b1; ex_pc = pc; B_imm = bimm; btaken = bt;
    ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic test_reset();
    clear_ex();
    rst_n = 1'b0;
    f_pc = 32'h100;
    #3;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b want 0", pred_hit); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %0b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_target got %h want 00000104", pred_target); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %0b want 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_rpc got %h want 0", redirect_pc); end
    checks++; if (mispredict_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", mispredict_cnt); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cold_branch();
    f_pc = 32'h100;
    drive_branch(32'h100, 32'h40, 1'b1, 1'b0, 32'h0);
    #1;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL cold_prehit got %0b want 0", pred_hit); end
    step();
    clear_ex();
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL cold_rv got %0b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h140) begin errors++; $display("FAIL cold_rpc got %h want 00000140", redirect_pc); end
    checks++; if (mispredict_cnt !== 4'd1) begin errors++; $display("FAIL cold_cnt got %0d want 1", mispredict_cnt); end
    #1;
    checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h140) begin
      errors++; $display("FAIL cold_lookup got hit=%0b tk=%0b tgt=%h want 1 1 00000140", pred_hit, pred_taken, pred_target);
    end
    step();
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h140) begin
      errors++; $display("FAIL cold_pulse got rv=%0b rpc=%h want 0 00000140", redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_hysteresis();
    f_pc = 32'h100;
    drive_branch(32'h100, 32'h40, 1'b0, 1'b1, 32'h140); // ctr 2->1, mispredict
    step();
    clear_ex(); #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104 || mispredict_cnt !== 4'd2) begin
      errors++; $display("FAIL hyst_nt_redirect got rv=%0b rpc=%h cnt=%0d want 1 00000104 2", redirect_valid, redirect_pc, mispredict_cnt);
    end
    checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++; $display("FAIL hyst_ctr1 got hit=%0b tk=%0b tgt=%h want 1 0 00000104", pred_hit, pred_taken, pred_target);
    end
    drive_branch(32'h100, 32'h40, 1'b1, 1'b0, 32'h104); // ctr 1->2, mispredict
    step();
    drive_branch(32'h100, 32'h40, 1'b1, 1'b1, 32'h140); // ctr 2->3, correct
    step();
    clear_ex(); #1;
    checks++; if (redirect_valid !== 1'b0 || mispredict_cnt !== 4'd3) begin
      errors++; $display("FAIL hyst_correct got rv=%0b cnt=%0d want 0 3", redirect_valid, mispredict_cnt);
    end
    drive_branch(32'h100, 32'h40, 1'b0, 1'b1, 32'h140); // ctr 3->2, mispredict
    step();
    clear_ex(); #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h140 || mispredict_cnt !== 4'd4) begin
      errors++; $display("FAIL hyst_ctr2 got tk=%0b tgt=%h cnt=%0d want 1 00000140 4", pred_taken, pred_target, mispredict_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      drive_branch(32'h100, 32'h40, 1'b0, 1'b0, 32'h0); // 2->1->0->0, all correct
      step();
    end
    clear_ex(); #1;
    checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || mispredict_cnt !== 4'd4) begin
      errors++; $display("FAIL hyst_sat0 got hit=%0b tk=%0b cnt=%0d want 1 0 4", pred_hit, pred_taken, mispredict_cnt);
    end
    drive_branch(32'h100, 32'h40, 1'b1, 1'b0, 32'h0); // ctr 0->1, mispredict
    step();
    clear_ex(); #1;
    checks++; if (pred_taken !== 1'b0 || mispredict_cnt !== 4'd5) begin
      errors++; $display("FAIL hyst_from0 got tk=%0b cnt=%0d want 0 5", pred_taken, mispredict_cnt);
    end
  endtask

  task automatic test_jalr();
    clear_ex();
    ex_valid = 1'b1; ex_is_ctrl = 1'b1; ex_pc = 32'h204; jr = 1'b1;
    operandA = 32'h2001; I_imm = 32'h4; ex_pred_taken = 1'b1; ex_pred_target = 32'h2004;
    step();
    checks++; if (redirect_valid !== 1'b0 || mispredict_cnt !== 4'd5) begin
      errors++; $display("FAIL jalr_ok got rv=%0b cnt=%0d want 0 5", redirect_valid, mispredict_cnt);
    end
    ex_pred_target = 32'h2008;
    step();
    clear_ex();
    f_pc = 32'h204; #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2004 || mispredict_cnt !== 4'd6) begin
      errors++; $display("FAIL jalr_bad got rv=%0b rpc=%h cnt=%0d want 1 00002004 6", redirect_valid, redirect_pc, mispredict_cnt);
    end
    checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h2004) begin
      errors++; $display("FAIL jalr_btb got hit=%0b tk=%0b tgt=%h want 1 1 00002004", pred_hit, pred_taken, pred_target);
    end
    step();
  endtask

  task automatic test_aliasing();
    f_pc = 32'h140; #1;
    checks++; if (pred_hit !== 1'b0 || pred_target !== 32'h144) begin
      errors++; $display("FAIL alias_miss got hit=%0b tgt=%h want 0 00000144", pred_hit, pred_target);
    end
    clear_ex();
    ex_valid = 1'b1; ex_is_ctrl = 1'b1; ex_pc = 32'h140; j = 1'b1; J_imm = 32'h80;
    step();
    clear_ex(); #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C0 || mispredict_cnt !== 4'd7) begin
      errors++; $display("FAIL alias_jal got rv=%0b rpc=%h cnt=%0d want 1 000001c0 7", redirect_valid, redirect_pc, mispredict_cnt);
    end
    checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h1C0) begin
      errors++; $display("FAIL alias_new got hit=%0b tk=%0b tgt=%h want 1 1 000001c0", pred_hit, pred_taken, pred_target);
    end
    f_pc = 32'h100; #1;
    checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL alias_old got hit=%0b want 0", pred_hit); end
    f_pc = 32'h140;
    drive_branch(32'h140, 32'h40, 1'b0, 1'b1, 32'h1C0); // ctr 3->2 proves jal allocated at 3
    step();
    clear_ex(); #1;
    checks++; if (pred_taken !== 1'b1 || redirect_pc !== 32'h144 || mispredict_cnt !== 4'd8) begin
      errors++; $display("FAIL alias_ctr3 got tk=%0b rpc=%h cnt=%0d want 1 00000144 8", pred_taken, redirect_pc, mispredict_cnt);
    end
  endtask

  task automatic test_same_cycle();
    f_pc = 32'h100;
    drive_branch(32'h100, 32'h20, 1'b1, 1'b0, 32'h0);
    #1;
    checks++; if (pred_hit !== 1'b0 || pred_target !== 32'h104) begin
      errors++; $display("FAIL same_old got hit=%0b tgt=%h want 0 00000104", pred_hit, pred_target);
    end
    step();
    clear_ex(); #1;
    checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h120 || mispredict_cnt !== 4'd9) begin
      errors++; $display("FAIL same_new got hit=%0b tk=%0b tgt=%h cnt=%0d want 1 1 00000120 9", pred_hit, pred_taken, pred_target, mispredict_cnt);
    end
  endtask

  task automatic test_no_resolve();
    f_pc = 32'h408;
    drive_branch(32'h408, 32'h40, 1'b1, 1'b0, 32'h0);
    ex_is_ctrl = 1'b0;
    step();
    drive_branch(32'h408, 32'h40, 1'b1, 1'b0, 32'h0);
    ex_valid = 1'b0;
    step();
    clear_ex(); #1;
    checks++; if (redirect_valid !== 1'b0 || mispredict_cnt !== 4'd9 || pred_hit !== 1'b0) begin
      errors++; $display("FAIL noresolve got rv=%0b cnt=%0d hit=%0b want 0 9 0", redirect_valid, mispredict_cnt, pred_hit);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_cnt;
    exp_cnt = 4'd9;
    f_pc = 32'h50C;
    drive_branch(32'h50C, 32'h40, 1'b0, 1'b1, 32'h54C);
    for (int k = 0; k < 7; k++) begin
      step();
      exp_cnt = exp_cnt + 4'd1;
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h510 || mispredict_cnt !== exp_cnt) begin
        errors++; $display("FAIL b2b_%0d got rv=%0b rpc=%h cnt=%0d want 1 00000510 %0d", k, redirect_valid, redirect_pc, mispredict_cnt, exp_cnt);
      end
    end
    clear_ex(); #1;
    checks++; if (mispredict_cnt !== 4'd0 || pred_hit !== 1'b0) begin
      errors++; $display("FAIL wrap got cnt=%0d hit=%0b want 0 0", mispredict_cnt, pred_hit);
    end
    step();
  endtask

  task automatic test_mid_reset();
    f_pc = 32'h100;
    drive_branch(32'h100, 32'h40, 1'b1, 1'b0, 32'h0);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || mispredict_cnt !== 4'd0) begin
      errors++; $display("FAIL midrst_regs got rv=%0b rpc=%h cnt=%0d want 0 0 0", redirect_valid, redirect_pc, mispredict_cnt);
    end
    checks++; if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++; $display("FAIL midrst_btb got hit=%0b tk=%0b tgt=%h want 0 0 00000104", pred_hit, pred_taken, pred_target);
    end
    step();
    clear_ex();
    rst_n = 1'b1;
    step();
    checks++; if (redirect_valid !== 1'b0 || pred_hit !== 1'b0 || mispredict_cnt !== 4'd0) begin
      errors++; $display("FAIL midrst_after got rv=%0b hit=%0b cnt=%0d want 0 0 0", redirect_valid, pred_hit, mispredict_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cold_branch();
    test_hysteresis();
    test_jalr();
    test_aliasing();
    test_same_cycle();
    test_no_resolve();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised successor of the execute-stage branch target unit. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for fetch-stage prediction.
- Resolves branches and jumps in execute, detects mispredictions, trains the BTB and issues a registered redirect to fetch.
- Keeps a wrapping mispredict performance counter.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 16, BTB entries; power of 2, >=2. IDX_W = log2(ENTRIES) is derived as a localparam.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- f_pc  input  XLEN  fetch PC to predict
- pred_hit  output  1  BTB valid and tag match for f_pc
- pred_taken  output  1  predicted taken
- pred_target  output  XLEN  predicted next PC
- ex_valid  input  1  execute slot holds a valid instruction
- ex_is_ctrl  input  1  instruction is branch/jal/jalr
- ex_pc  input  XLEN  PC of execute instruction
- operandA  input  XLEN  rs1 value
- B_imm, J_imm, I_imm  input  XLEN  sign-extended immediates
- btaken  input  1  branch condition true
- jr  input  1  jalr
- j  input  1  jal
- ex_pred_taken  input  1  prediction carried down the pipe
- ex_pred_target  input  XLEN  predicted target carried down the pipe
- redirect_valid  output  1  one-cycle redirect pulse
- redirect_pc  output  XLEN  correct next PC
- mispredict_cnt  output  CNT_W  mispredict count, wraps

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. Each entry holds valid, tag, target[XLEN], ctr[1:0].
- Lookup is combinational from registered state, zero latency.
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & ctr[1].
  - pred_target = pred_taken ? entry target : f_pc+4.
- Actual target:
  - j: ex_pc+J_imm.
  - jr: (operandA+I_imm) with bit0 forced to 0.
  - otherwise btaken ? ex_pc+B_imm : ex_pc+4.
- actual_taken = j | jr | btaken. All adds are modulo 2^XLEN.
- resolve = ex_valid & ex_is_ctrl.
- mispredict = resolve & ((actual_taken != ex_pred_taken) | (actual_taken & target != ex_pred_target)).
- Redirect (registered, 1-cycle latency):
  - On the clk edge after a mispredict, redirect_valid=1 for exactly one cycle.
  - redirect_pc = actual_taken ? target : ex_pc+4.
  - Otherwise redirect_valid=0 and redirect_pc holds its last value.
- BTB training happens at the clk edge when resolve=1:
  - Hit, taken: ctr saturating increment (max 3); target overwritten with actual target.
  - Hit, not taken: ctr saturating decrement (min 0); target unchanged.
  - Miss/tag mismatch, taken: allocate/replace entry: valid=1, new tag, target; ctr=3 if j|jr, else ctr=2.
  - Miss, not taken: no write.
- Lookup and update on the same index in the same cycle: lookup returns pre-update contents; the update is visible the next cycle.
- mispredict_cnt increments by 1 on each mispredict edge and wraps from all-ones to 0.
- ex_valid=0 or ex_is_ctrl=0: no training, no redirect, no count.
- Reset (async assert, any time, including mid-update):
  - all valid=0, ctr=0, target=0.
  - redirect_valid=0, redirect_pc=0, mispredict_cnt=0.
  - Consequently pred_hit=0, pred_taken=0, pred_target=f_pc+4.
  - Deassertion is synchronous to clk (synchroniser is external).

Test Plan:
- Reset then f_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; redirect_valid=0, mispredict_cnt=0.
- Cold branch: ex_pc=0x100, B_imm=0x40, btaken=1, ex_pred_taken=0 -> next cycle redirect_valid=1 for one cycle, redirect_pc=0x140, mispredict_cnt=1. Then f_pc=0x100 -> pred_hit=1, pred_taken=1 (ctr=2), pred_target=0x140.
- Hysteresis: from ctr=2, resolve not-taken once -> ctr=1, pred_taken=0. Resolve taken twice -> ctr=3. One not-taken -> ctr=2, still predicts taken. Three more not-taken -> ctr saturates at 0.
- jalr: jr=1, operandA=0x2001, I_imm=0x4, ex_pred_taken=1, ex_pred_target=0x2004 -> target 0x2004, no redirect, no count. Same with ex_pred_target=0x2008 -> redirect_pc=0x2004.
- Aliasing (ENTRIES=16): train 0x100 taken, then lookup 0x140 (same index, different tag) -> pred_hit=0. A taken jal at 0x140 replaces the entry with ctr=3. Lookup 0x100 then misses.
- Same-cycle update/lookup on one index shows old data that cycle and new data the next. Assert rst_n mid-stream -> all outputs return to reset values immediately. Force mispredict_cnt to all-ones via 2^CNT_W mispredicts (CNT_W=4 build) -> wraps to 0.
